count_hex_uart_tx: RTL

Consumes the `{data, valid, last}` count stream produced by the counting stage. Buffers each word in a small FIFO and transmits it on a UART TX line as uppercase ASCII hex. Words within a frame are separated by a space, and each frame ends with CR LF after its last word. It is the output stage between the counter and the board's serial pin. The upstream stage has no backpressure, so this block absorbs bursts and reports any loss with a sticky overflow flag.

---
 rtl/count_hex_uart_tx_if.sv | 15 +
 rtl/count_hex_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_hex_uart_tx_if.sv
// Count stream carried from the counting stage into the UART hex printer.
//   in_data  : stream word
//   in_valid : word present this cycle (no backpressure exists)
//   in_last  : word closes its frame
// master drives the stream, slave (count_hex_uart_tx) consumes it.
interface count_hex_uart_tx_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;

    modport master (output in_data, output in_valid, output in_last);
    modport slave  (input  in_data, input  in_valid, input  in_last);
endinterface

// File: rtl/count_hex_uart_tx.sv
// Prints the counter's {data, valid, last} stream on a UART TX pin as
// uppercase ASCII hex. Words inside a frame are separated by a space, and a
// frame ends with CR LF. Words are buffered in a small FIFO. Words that
// arrive while the FIFO is full are dropped, and the drop is flagged
// through a sticky overflow flag.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   s_in       : count stream (slave modport)
//   tx         : UART line, idle high, 8N1, CLKS_PER_BIT cycles per bit
//   busy       : FIFO non-empty or formatter not idle
//   overflow   : sticky, at least one word dropped since reset
//   frame_done : one-cycle pulse on the last cycle of the LF stop bit
module count_hex_uart_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 3
) (
    input  logic              clk,
    input  logic              rst,
    count_hex_uart_tx_if.slave s_in,
    output logic              tx,
    output logic              busy,
    output logic              overflow,
    output logic              frame_done
);

    localparam int DIGITS = DATA_WIDTH / 4;
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]  BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [FIFO_AW:0]   FIFO_FULL   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [1:0]         TOP_IDX     = 2'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DIGIT,
        SEP,
        CR,
        LF
    } state_t;

    // ------------------------------------------------------------------
    // FIFO of {last, data}
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    // ------------------------------------------------------------------
    // Formatter / transmitter state
    // ------------------------------------------------------------------
    state_t                state;
    state_t                nxt_state;
    logic                  sending;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [3:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_last;
    logic [1:0]            digit_idx;
    logic [1:0]            nxt_idx;
    logic [7:0]            cur_char;
    logic [7:0]            nxt_char;
    logic                  bit_end;
    logic                  char_end;

    function automatic logic [7:0] char_for(input state_t st,
                                            input logic [1:0] idx,
                                            input logic [DATA_WIDTH-1:0] d);
        logic [3:0] nib;
        logic [7:0] c;
        nib = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == 2'(i)) begin
                nib = d[4*i +: 4];
            end
        end
        case (st)
            DIGIT:   c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
            SEP:     c = 8'h20;
            CR:      c = 8'h0D;
            LF:      c = 8'h0A;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);
    assign {rd_last, rd_data} = mem[rd_ptr];

    assign bit_end  = sending && (baud_cnt == BAUD_LAST);
    assign char_end = bit_end && (bit_cnt == 4'd9);

    // A word is popped from IDLE, or directly at the end of a SEP/LF stop bit
    // so that consecutive words cost only one extra load cycle.
    assign pop  = !fifo_empty &&
                  ((state == IDLE) || (char_end && ((state == SEP) || (state == LF))));
    assign push = s_in.in_valid && (!fifo_full || pop);

    assign busy = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_in.in_last, s_in.in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_in.in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Next character in the chain, used to start it on the same edge the
    // current stop bit ends (no idle gap between characters).
    always_comb begin
        nxt_state = state;
        nxt_idx   = digit_idx;
        case (state)
            DIGIT: begin
                if (digit_idx != '0) begin
                    nxt_idx = digit_idx - 2'd1;
                end else begin
                    nxt_state = hold_last ? CR : SEP;
                end
            end
            CR:      nxt_state = LF;
            default: nxt_state = IDLE;
        endcase
    end

    assign cur_char = char_for(state, digit_idx, hold_data);
    assign nxt_char = char_for(nxt_state, nxt_idx, hold_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sending    <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            digit_idx  <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == LF) && sending && (bit_cnt == 4'd9) &&
                          (baud_cnt == BAUD_PENULT);

            if (state == IDLE) begin
                if (pop) begin
                    hold_data <= rd_data;
                    hold_last <= rd_last;
                    digit_idx <= TOP_IDX;
                    state     <= DIGIT;
                end
            end else if (!sending) begin
                // First character after a pop: start bit.
                sending  <= 1'b1;
                tx       <= 1'b0;
                shreg    <= cur_char;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt <= 4'd7) begin
                    tx      <= shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd8) begin
                    tx      <= 1'b1;
                    bit_cnt <= 4'd9;
                end else if ((state == SEP) || (state == LF)) begin
                    sending <= 1'b0;
                    if (pop) begin
                        hold_data <= rd_data;
                        hold_last <= rd_last;
                        digit_idx <= TOP_IDX;
                        state     <= DIGIT;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    state     <= nxt_state;
                    digit_idx <= nxt_idx;
                    tx        <= 1'b0;
                    shreg     <= nxt_char;
                    bit_cnt   <= '0;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule
